// File: rtl/pow_fsmd.sv
// Square-and-multiply integer power engine: result_o = base_i ** exp_i (low WIDTH bits) with overflow flag.
// Optional macro POW_SATURATE_EN: an overflowed result loads all-ones instead of the wrapped value.
module pow_fsmd #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go_i,
  input  logic [WIDTH-1:0]     base_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  output logic [WIDTH-1:0]     result_o,
  output logic                 ovf_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    INIT      = 3'b001,
    CHECK     = 3'b010,
    PROC_EVEN = 3'b011,
    PROC_ODD  = 3'b100,
    DONE      = 3'b101
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     r_reg;
  logic [EXP_WIDTH-1:0] n_reg;
  logic                 ovf_acc;

  logic [2*WIDTH-1:0]   sq_full;
  logic [2*WIDTH-1:0]   mul_full;
  logic [EXP_WIDTH-1:0] n_half;
  logic                 sq_ovf;
  logic                 mul_ovf;

  // Full-precision products; the square only matters if it will be used again.
  assign sq_full  = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, a_reg};
  assign mul_full = {{WIDTH{1'b0}}, r_reg} * {{WIDTH{1'b0}}, a_reg};
  assign n_half   = n_reg >> 1;
  assign sq_ovf   = (|sq_full[2*WIDTH-1:WIDTH]) && (n_half != '0);
  assign mul_ovf  = |mul_full[2*WIDTH-1:WIDTH];

  assign busy_o  = (state != IDLE);
  assign state_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:      state_nxt = go_i ? INIT : IDLE;
      INIT:      state_nxt = CHECK;
      CHECK: begin
        if (n_reg == '0)     state_nxt = DONE;
        else if (!n_reg[0])  state_nxt = PROC_EVEN;
        else                 state_nxt = PROC_ODD;
      end
      PROC_EVEN: state_nxt = CHECK;
      PROC_ODD:  state_nxt = CHECK;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg    <= '0;
      n_reg    <= '0;
      r_reg    <= '0;
      ovf_acc  <= 1'b0;
      result_o <= '0;
      ovf_o    <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= (state == DONE);
      case (state)
        IDLE: begin
          if (go_i) begin
            a_reg <= base_i;
            n_reg <= exp_i;
          end
        end
        INIT: begin
          r_reg   <= {{(WIDTH-1){1'b0}}, 1'b1};
          ovf_acc <= 1'b0;
        end
        PROC_EVEN: begin
          a_reg <= sq_full[WIDTH-1:0];
          n_reg <= n_half;
          if (sq_ovf) ovf_acc <= 1'b1;
        end
        PROC_ODD: begin
          r_reg <= mul_full[WIDTH-1:0];
          a_reg <= sq_full[WIDTH-1:0];
          n_reg <= n_half;
          if (sq_ovf || mul_ovf) ovf_acc <= 1'b1;
        end
        DONE: begin
`ifdef POW_SATURATE_EN
          result_o <= ovf_acc ? '1 : r_reg;
`else
          result_o <= r_reg;
`endif
          ovf_o <= ovf_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_fsmd.sv
// Bench for pow_fsmd: naive repeated-multiplication reference, cycle-level completion model, per-cycle compare.
module tb_pow_fsmd;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go_i = 1'b0;
  logic [W-1:0] base_i = '0;
  logic [W-1:0] exp_i = '0;
  logic [W-1:0] result_o;
  logic         ovf_o;
  logic         busy_o;
  logic         done_o;
  logic [2:0]   state_o;

  pow_fsmd #(.WIDTH(W), .EXP_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .go_i(go_i), .base_i(base_i), .exp_i(exp_i),
    .result_o(result_o), .ovf_o(ovf_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {ovf, result}: ovf means the true power does not fit in W bits.
  function automatic logic [W:0] pow_ref(input logic [W-1:0] b, input logic [W-1:0] e);
    int unsigned  big = 1;
    logic [W-1:0] wr = 1;
    logic         ovf;
    for (int i = 0; i < int'(e); i++) begin
      wr  = W'(wr * b);
      big = big * b;
      if (big > (1 << W)) big = 1 << W;
    end
    ovf = (big >= (1 << W));
`ifdef POW_SATURATE_EN
    if (ovf) wr = '1;
`endif
    return {ovf, wr};
  endfunction

  function automatic int sig_bits(input logic [W-1:0] e);
    int k = 0;
    logic [W-1:0] v = e;
    while (v != 0) begin
      k++;
      v = v >> 1;
    end
    return k;
  endfunction

  // ---------------- scoreboard / cycle model ----------------
  logic [W:0]   exp_q[$];
  int           cnt = 0;          // edges left until the operation completes
  logic         exp_done = 1'b0;
  logic [W-1:0] last_res = '0;
  logic         last_ovf = 1'b0;
  logic         checking = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt = 0;
      exp_done = 1'b0;
      last_res = '0;
      last_ovf = 1'b0;
      exp_q.delete();
    end else begin
      logic [W:0] item;
      exp_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          exp_done = 1'b1;
          if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            last_ovf = item[W];
            last_res = item[W-1:0];
          end
        end
      end else if (go_i) begin
        exp_q.push_back(pow_ref(base_i, exp_i));
        cnt = 2 * sig_bits(exp_i) + 3;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && checking) begin
      check("busy", 32'(busy_o), 32'(cnt != 0));
      check("done", 32'(done_o), 32'(exp_done));
      check("result", 32'(result_o), 32'(last_res));
      check("ovf", 32'(ovf_o), 32'(last_ovf));
      if (cnt == 0) check("state_idle", 32'(state_o), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_model_idle();
    int guard = 0;
    @(negedge clk);
    while (cnt != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cnt != 0) check("idle_timeout", 32'(cnt), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] req_res, input logic req_ovf, input int req_lat);
    int lat;
    wait_model_idle();
    go_i = 1'b1; base_i = b; exp_i = e;
    @(negedge clk);
    go_i = 1'b0; base_i = W'($urandom); exp_i = W'($urandom);
    lat = 1;
    while (!done_o && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("lat_%0d^%0d", b, e), 32'(lat), 32'(req_lat));
    check($sformatf("res_%0d^%0d", b, e), 32'(result_o), 32'(req_res));
    check($sformatf("ovf_%0d^%0d", b, e), 32'(ovf_o), 32'(req_ovf));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W:0] r;
    int         guard;
    int         pulses;

    // Literal pins on the reference model.
    r = pow_ref(3, 5);   check("ref_3^5", 32'(r), {23'd0, 1'b0, 8'd243});
    r = pow_ref(2, 7);   check("ref_2^7", 32'(r), {23'd0, 1'b0, 8'd128});
    r = pow_ref(2, 8);
`ifdef POW_SATURATE_EN
    check("ref_2^8", 32'(r), {23'd0, 1'b1, 8'd255});
`else
    check("ref_2^8", 32'(r), {23'd0, 1'b1, 8'd0});
`endif
    r = pow_ref(0, 0);   check("ref_0^0", 32'(r), 32'd1);
    r = pow_ref(0, 3);   check("ref_0^3", 32'(r), 32'd0);
    r = pow_ref(1, 200); check("ref_1^200", 32'(r), 32'd1);
    r = pow_ref(15, 2);  check("ref_15^2", 32'(r), 32'd225);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    checking = 1'b1;

    // Directed operations with hand-computed results and latencies.
    run_op(3, 5, 243, 1'b0, 10);
    run_op(2, 7, 128, 1'b0, 10);
`ifdef POW_SATURATE_EN
    run_op(2, 8, 255, 1'b1, 12);
`else
    run_op(2, 8, 0, 1'b1, 12);
`endif
    run_op(0, 0, 1, 1'b0, 4);
    run_op(7, 0, 1, 1'b0, 4);
    run_op(0, 3, 0, 1'b0, 8);
    run_op(1, 255, 1, 1'b0, 20);

    // Reset in the middle of an operation.
    wait_model_idle();
    go_i = 1'b1; base_i = 3; exp_i = 5;
    @(negedge clk);
    go_i = 1'b0;
    guard = 0;
    while (state_o != 3'b100 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("reach_proc_odd", 32'(state_o), 32'd4);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_result", 32'(result_o), 32'd0);
    check("mid_rst_ovf", 32'(ovf_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);  // per-cycle compare sees no done pulse here
    run_op(5, 3, 125, 1'b0, 8);

    // go held high: back-to-back operations, one done pulse every 8 cycles.
    wait_model_idle();
    go_i = 1'b1; base_i = 3; exp_i = 2;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) begin
        pulses++;
        check("held_go_res", 32'(result_o), 32'd9);
      end
    end
    go_i = 1'b0;
    check("held_go_pulses", 32'(pulses), 32'd5);

    // Randomized traffic: go and operands change freely, including while busy.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      go_i   = ($urandom_range(0, 3) == 0);
      base_i = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      exp_i  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
    end
    go_i = 1'b0;
    wait_model_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pow_fsmd.md
POW_FSMD -- requirements
Module: pow_fsmd

Interface
REQ-001 Parameter WIDTH, default 8: bit width of base_i, the running base, the running result and result_o.
REQ-002 Parameter EXP_WIDTH, default 8: bit width of exp_i and the running exponent.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 go_i  input  1  start request; sampled only in IDLE.
REQ-006 base_i  input  WIDTH  base operand; captured on the edge that accepts go_i.
REQ-007 exp_i  input  EXP_WIDTH  exponent operand; captured on the edge that accepts go_i.
REQ-008 result_o  output  WIDTH  registered result; held until the next completion.
REQ-009 ovf_o  output  1  registered overflow flag for result_o.
REQ-010 busy_o  output  1  high whenever state is not IDLE.
REQ-011 done_o  output  1  registered one-cycle completion pulse.
REQ-012 state_o  output  3  current state encoding, for debug.

Function
REQ-013 States and encodings SHALL be IDLE=000, INIT=001, CHECK=010, PROC_EVEN=011, PROC_ODD=100, DONE=101; unused codes SHALL go to IDLE.
REQ-014 IDLE SHALL go to INIT when go_i=1 and SHALL capture base_i into a_reg and exp_i into n_reg; otherwise it SHALL stay in IDLE.
REQ-015 INIT SHALL set r_reg=1, clear the internal ovf accumulator, and go to CHECK.
REQ-016 CHECK SHALL go to DONE if n_reg==0, to PROC_EVEN if n_reg[0]==0, and to PROC_ODD otherwise.
REQ-017 PROC_EVEN SHALL set a_reg=a_reg*a_reg (low WIDTH bits) and n_reg=n_reg>>1, then go to CHECK.
REQ-018 PROC_ODD SHALL set r_reg=r_reg*a_reg and a_reg=a_reg*a_reg (both low WIDTH bits) and n_reg=n_reg>>1, then go to CHECK.
REQ-019 Each product SHALL be computed at full 2*WIDTH precision.
REQ-020 A nonzero upper half of the r_reg product SHALL set the ovf accumulator.
REQ-021 A nonzero upper half of the a_reg square SHALL set the ovf accumulator only when the new n_reg (n_reg>>1) is nonzero.
REQ-022 DONE SHALL go to IDLE; on that edge result_o and ovf_o SHALL load and done_o SHALL be 1 for the following cycle only.
REQ-023 Latency: for an exponent with k significant bits, done_o SHALL rise 2k+4 cycles after the edge that accepted go_i; exponent 0 gives 4 cycles.
REQ-024 go_i SHALL be ignored when the state is not IDLE, and operand changes during an operation SHALL have no effect.
REQ-025 With go_i held high, a new operation SHALL start on the edge that returns the block to IDLE+1 cycle (the first IDLE cycle); back-to-back operations SHALL be supported.
REQ-026 Boundary values: 0^0=1, x^0=1, 0^e=0 for e>0, 1^e=1; none of these SHALL set ovf.

Reset
REQ-027 On rst=0, the block SHALL immediately set state=IDLE, result_o=0, ovf_o=0, done_o=0, busy_o=0, a_reg=0, n_reg=0, r_reg=0.
REQ-028 Reset mid-operation SHALL abandon the operation with no done_o pulse.
REQ-029 The first operation after reset release SHALL behave as from power-up.

Configuration
REQ-030 Macro POW_SATURATE_EN, when defined: if the ovf accumulator is set at DONE, result_o SHALL load all-ones; ovf_o=1.
REQ-031 Without POW_SATURATE_EN: result_o SHALL load the wrapped low WIDTH bits of r_reg; ovf_o still reports overflow.

Verification
REQ-032 WIDTH=8, base=3, exp=5 -> result_o=243, ovf_o=0, done_o 10 cycles after go accepted.
REQ-033 base=2, exp=7 -> result_o=128, ovf_o=0 (the final square 256 is not flagged).
REQ-034 base=2, exp=8 -> ovf_o=1; result_o=0 without the macro, 255 with POW_SATURATE_EN.
REQ-035 base=0, exp=0 and base=7, exp=0 -> result_o=1, ovf_o=0, latency 4 cycles; base=0, exp=3 -> result_o=0.
REQ-036 Start base=3, exp=5, assert rst=0 in PROC_ODD -> immediate IDLE, outputs 0, no done_o; next op base=5, exp=3 -> result_o=125.
REQ-037 go_i held high continuously with base=3, exp=2 -> repeated done_o pulses, result_o=9 each time, and go_i pulses during busy_o ignored.
